// File: rtl/dms_pfd_pkg.sv
// Shared types and constants for the digital phase/frequency detector.
//
// Contents:
//   PFD_ERR_W        width of the signed phase-error word
//   PFD_ERR_POS_SAT  positive saturation value of the width counter
//   PFD_ERR_NEG_SAT  negative saturation value of the width counter
//   pfd_state_t      detector FSM state encoding
//   pfd_err_t        signed phase-error word
//   pfd_mag_t        unsigned magnitude of a phase-error word
//   pfd_abs()        magnitude helper used by the lock qualifier
package dms_pfd_pkg;

  localparam int unsigned PFD_ERR_W = 8;

  typedef logic signed [PFD_ERR_W-1:0] pfd_err_t;
  typedef logic        [PFD_ERR_W-1:0] pfd_mag_t;

  // Symmetric saturation keeps -128 out of the range, so pfd_abs never overflows.
  localparam pfd_err_t PFD_ERR_POS_SAT = 8'sd127;
  localparam pfd_err_t PFD_ERR_NEG_SAT = -8'sd127;

  typedef enum logic [1:0] {
    PFD_IDLE = 2'd0,
    PFD_UP   = 2'd1,
    PFD_DOWN = 2'd2,
    PFD_BOTH = 2'd3
  } pfd_state_t;

  function automatic pfd_mag_t pfd_abs(input pfd_err_t v);
    pfd_err_t neg;
    neg = -v;
    return v[PFD_ERR_W-1] ? pfd_mag_t'(neg) : pfd_mag_t'(v);
  endfunction

endpackage

// File: rtl/dms_edge_sync.sv
// Two-flop synchronizer followed by a history flop and rising-edge detector.
//
// Ports:
//   clk   sampling clock
//   rst   synchronous active-high reset, clears all three flops
//   d     asynchronous input level
//   rise  one-cycle pulse when the synchronized level goes 0 -> 1
module dms_edge_sync
  import dms_pfd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/dms_pfd.sv
// Digital phase/frequency detector with anti-dead-zone pulse, signed phase
// measurement and lock detection.
//
// Parameters:
//   MIN_PULSE  cycles up and down are both held high after a measurement (1..15)
//   LOCK_CNT   consecutive in-window measurements needed to assert lock (2..255)
//   LOCK_WIN   largest |phase_err| (clk cycles) treated as in-window
//
// Ports:
//   clk        sampling clock, all state updates on its rising edge
//   rst        synchronous active-high reset, overrides enable
//   enable     detector enable, low forces idle and clears lock tracking
//   ref_in     reference clock, asynchronous to clk
//   fb_in      divided VCO feedback clock, asynchronous to clk
//   up         charge-pump source control (registered)
//   down       charge-pump sink control (registered)
//   phase_err  signed last measured phase error, + means ref leads
//   err_valid  one-cycle pulse when phase_err updates
//   lock       lock indicator (registered)
module dms_pfd
  import dms_pfd_pkg::*;
#(
  parameter int unsigned MIN_PULSE = 2,
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned LOCK_WIN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        ref_in,
  input  logic                        fb_in,
  output logic                        up,
  output logic                        down,
  output logic signed [PFD_ERR_W-1:0] phase_err,
  output logic                        err_valid,
  output logic                        lock
);

  localparam logic [3:0] BothLast = 4'(MIN_PULSE - 1);
  localparam logic [7:0] LockMax  = 8'(LOCK_CNT);
  localparam pfd_mag_t   LockWin  = pfd_mag_t'(LOCK_WIN);

  // Edge detection. The synchronizers run regardless of enable so that history
  // is always current and re-enabling never sees a stale edge.
  logic ref_rise;
  logic fb_rise;

  dms_edge_sync u_ref_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ref_in),
    .rise (ref_rise)
  );

  dms_edge_sync u_fb_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (fb_in),
    .rise (fb_rise)
  );

  pfd_state_t state_q, state_d;
  pfd_err_t   width_q, width_d;
  pfd_err_t   err_q, err_d;
  logic       ev_q, ev_d;
  logic [3:0] both_q, both_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       lock_q, lock_d;

  // Detector FSM and signed width counter.
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    both_d  = both_q;
    err_d   = err_q;
    ev_d    = 1'b0;

    if (!enable) begin
      state_d = PFD_IDLE;
      width_d = '0;
      both_d  = '0;
    end else begin
      unique case (state_q)
        PFD_IDLE: begin
          if (ref_rise && fb_rise) begin
            state_d = PFD_BOTH;
            both_d  = '0;
            width_d = '0;
            err_d   = '0;
            ev_d    = 1'b1;
          end else if (ref_rise) begin
            state_d = PFD_UP;
            width_d = 8'sd1;
          end else if (fb_rise) begin
            state_d = PFD_DOWN;
            width_d = -8'sd1;
          end
        end

        PFD_UP: begin
          if (fb_rise) begin
            state_d = PFD_BOTH;
            both_d  = '0;
            err_d   = width_q;
            ev_d    = 1'b1;
            width_d = '0;
          end else if (width_q != PFD_ERR_POS_SAT) begin
            // A repeated ref edge just keeps counting: frequency-detect mode.
            width_d = width_q + 8'sd1;
          end
        end

        PFD_DOWN: begin
          if (ref_rise) begin
            state_d = PFD_BOTH;
            both_d  = '0;
            err_d   = width_q;
            ev_d    = 1'b1;
            width_d = '0;
          end else if (width_q != PFD_ERR_NEG_SAT) begin
            width_d = width_q - 8'sd1;
          end
        end

        PFD_BOTH: begin
          // Edges are deliberately ignored here; the pulse has a fixed width.
          if (both_q >= BothLast) begin
            state_d = PFD_IDLE;
            both_d  = '0;
          end else begin
            both_d = both_q + 4'd1;
          end
        end

        default: state_d = PFD_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    up_d   = (state_d == PFD_UP)   || (state_d == PFD_BOTH);
    down_d = (state_d == PFD_DOWN) || (state_d == PFD_BOTH);
  end

  // Lock qualifier works on the registered measurement, so lock reacts one
  // cycle after the err_valid pulse it is judging.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!enable) begin
      lock_cnt_d = '0;
    end else if (ev_q) begin
      if (pfd_abs(err_q) <= LockWin) begin
        if (lock_cnt_q != LockMax) begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end else begin
        lock_cnt_d = '0;
      end
    end
    lock_d = (lock_cnt_d == LockMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PFD_IDLE;
      width_q    <= '0;
      err_q      <= '0;
      ev_q       <= 1'b0;
      both_q     <= '0;
      lock_cnt_q <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      err_q      <= err_d;
      ev_q       <= ev_d;
      both_q     <= both_d;
      lock_cnt_q <= lock_cnt_d;
      up_q       <= up_d;
      down_q     <= down_d;
      lock_q     <= lock_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign phase_err = err_q;
  assign err_valid = ev_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_dms_pfd.sv
// Directed bench for dms_pfd: square-wave generators for ref_in/fb_in are
// stepped once per clk, and per-window statistics of the outputs are compared
// against hand-derived values.
module tb_dms_pfd;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              ref_in;
  logic              fb_in;
  logic              up;
  logic              down;
  logic signed [7:0] phase_err;
  logic              err_valid;
  logic              lock;

  int checks = 0;
  int errors = 0;

  // Generator state: period, high time and phase counter for each input.
  int pr, hr, rc, pf, hf, fc;
  bit gen_on = 0;

  // Window statistics.
  int n, first_up, up_only, dn_only, both_cnt, ev_cnt, last_err;
  int lock_at_ev, lock_after_ev;
  bit prev_ev;

  dms_pfd #(
    .MIN_PULSE (2),
    .LOCK_CNT  (64),
    .LOCK_WIN  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .up        (up),
    .down      (down),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .lock      (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n = 0; first_up = 0; up_only = 0; dn_only = 0; both_cnt = 0;
    ev_cnt = 0; last_err = 0; lock_at_ev = -1; lock_after_ev = -1; prev_ev = 0;
  endtask

  task automatic start_gen(input int p_r, input int h_r, input int c_r,
                           input int p_f, input int h_f, input int c_f);
    pr = p_r; hr = h_r; rc = c_r; pf = p_f; hf = h_f; fc = c_f;
    gen_on = 1;
    ref_in = (rc < hr);
    fb_in  = (fc < hf);
  endtask

  // One clk cycle: sample 1 time unit after the edge, then step the inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    n++;
    if (up && first_up == 0) first_up = n;
    if (up && !down) up_only++;
    if (down && !up) dn_only++;
    if (up && down) both_cnt++;
    if (err_valid) begin
      ev_cnt++;
      last_err = phase_err;
      lock_at_ev = lock;
    end
    if (prev_ev) lock_after_ev = lock;
    prev_ev = err_valid;
    if (gen_on) begin
      rc = (rc + 1) % pr;
      fc = (fc + 1) % pf;
      ref_in = (rc < hr);
      fb_in  = (fc < hf);
    end
  endtask

  task automatic do_reset();
    gen_on = 0;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    clear_stats();
    cyc();
    cyc();
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_err", int'(phase_err), 0);
    check("rst_ev", int'(err_valid), 0);
    check("rst_lock", int'(lock), 0);
    rst = 1'b0;
    cyc();
    check("idle_up", int'(up), 0);

    // Ref leads fb by 10 cycles, 100-cycle period.
    clear_stats();
    start_gen(100, 50, 0, 100, 50, 90);
    repeat (100) cyc();
    check("lead10_latency", first_up, 3);
    check("lead10_up", up_only, 10);
    check("lead10_both", both_cnt, 2);
    check("lead10_down", dn_only, 0);
    check("lead10_ev", ev_cnt, 1);
    check("lead10_err", last_err, 10);
    check("lead10_end_up", int'(up), 0);

    // Fb leads ref by 5 cycles.
    do_reset();
    clear_stats();
    start_gen(100, 50, 95, 100, 50, 0);
    repeat (100) cyc();
    check("lag5_down", dn_only, 5);
    check("lag5_up", up_only, 0);
    check("lag5_both", both_cnt, 2);
    check("lag5_ev", ev_cnt, 1);
    check("lag5_err", last_err, -5);

    // Coincident edges every 20 cycles until lock, then one 5-cycle offset.
    do_reset();
    clear_stats();
    start_gen(20, 10, 0, 20, 10, 0);
    repeat (1260) cyc();
    check("coin63_ev", ev_cnt, 63);
    check("coin63_lock", int'(lock), 0);
    repeat (20) cyc();
    check("coin64_ev", ev_cnt, 64);
    check("coin64_err", last_err, 0);
    check("coin64_up_only", up_only, 0);
    check("coin64_dn_only", dn_only, 0);
    check("coin64_both", both_cnt, 128);
    check("coin64_lock_at_ev", lock_at_ev, 0);
    check("coin64_lock_after", lock_after_ev, 1);
    check("coin64_lock", int'(lock), 1);
    clear_stats();
    fc = 15;
    fb_in = 1'b0;
    repeat (20) cyc();
    check("off5_err", last_err, 5);
    check("off5_up", up_only, 5);
    check("off5_lock_at_ev", lock_at_ev, 1);
    check("off5_lock_after", lock_after_ev, 0);
    check("off5_lock", int'(lock), 0);

    // Ref at twice the fb frequency, fb edge 170 cycles late: saturation.
    do_reset();
    clear_stats();
    start_gen(160, 20, 0, 320, 20, 150);
    repeat (180) cyc();
    check("freq_up", up_only, 170);
    check("freq_down", dn_only, 0);
    check("freq_both", both_cnt, 2);
    check("freq_ev", ev_cnt, 1);
    check("freq_err_sat", last_err, 127);

    // rst while up is high, then a clean measurement.
    do_reset();
    clear_stats();
    start_gen(100, 50, 0, 100, 50, 90);
    repeat (6) cyc();
    check("pre_rst_up", int'(up), 1);
    gen_on = 0; ref_in = 1'b0; fb_in = 1'b0;
    rst = 1'b1;
    cyc();
    check("midrst_up", int'(up), 0);
    check("midrst_down", int'(down), 0);
    check("midrst_err", int'(phase_err), 0);
    check("midrst_ev", int'(err_valid), 0);
    check("midrst_lock", int'(lock), 0);
    rst = 1'b0;
    clear_stats();
    start_gen(100, 50, 0, 100, 50, 90);
    repeat (100) cyc();
    check("postrst_err", last_err, 10);
    check("postrst_ev", ev_cnt, 1);
    check("postrst_up", up_only, 10);

    // enable low while up is high; re-enable with fb level already high.
    repeat (6) cyc();
    check("pre_dis_up", int'(up), 1);
    enable = 1'b0;
    cyc();
    check("dis_up", int'(up), 0);
    check("dis_down", int'(down), 0);
    check("dis_ev", int'(err_valid), 0);
    check("dis_lock", int'(lock), 0);
    check("dis_err_hold", int'(phase_err), 10);
    clear_stats();
    repeat (50) cyc();
    enable = 1'b1;
    repeat (143) cyc();
    check("reen_ev", ev_cnt, 1);
    check("reen_err", last_err, 10);
    check("reen_up", up_only, 10);
    check("reen_down", dn_only, 0);
    check("reen_both", both_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dms_pfd.md
DMS_PFD -- requirements
Module: dms_pfd

Interface
REQ-001 Parameter MIN_PULSE, default 2, cycles both up and down are held high in the anti-dead-zone reset phase (range 1..15).
REQ-002 Parameter LOCK_CNT, default 64, consecutive in-window comparisons required to assert lock (range 2..255).
REQ-003 Parameter LOCK_WIN, default 1, max |phase_err| in clk cycles counted as in-window.
REQ-004 Port clk  input  1  sampling clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port enable  input  1  detector enable; low forces idle.
REQ-007 Port ref_in  input  1  reference clock, asynchronous to clk.
REQ-008 Port fb_in  input  1  divided VCO feedback clock, asynchronous to clk.
REQ-009 Port up  output  1  charge-pump source control, registered.
REQ-010 Port down  output  1  charge-pump sink control, registered.
REQ-011 Port phase_err  output  8  signed; last measured phase error in clk cycles (+ = ref leads).
REQ-012 Port err_valid  output  1  one-cycle pulse when phase_err updates.
REQ-013 Port lock  output  1  lock indicator, registered.

Function
REQ-014 ref_in and fb_in SHALL each pass a 2-flop synchronizer plus one history flop; a rising edge is sync2 & ~hist.
REQ-015 FSM states SHALL be IDLE, UP, DOWN, BOTH; up=1 in UP/BOTH, down=1 in DOWN/BOTH, else 0.
REQ-016 IDLE: ref edge only -> UP; fb edge only -> DOWN; both edges same cycle -> BOTH with phase_err=0.
REQ-017 UP: fb edge -> BOTH; repeated ref edge -> stay UP (frequency-detect behaviour, no error).
REQ-018 DOWN: ref edge -> BOTH; repeated fb edge -> stay DOWN.
REQ-019 BOTH SHALL last exactly MIN_PULSE cycles then -> IDLE; edges arriving during BOTH SHALL be ignored.
REQ-020 Latency: up/down SHALL rise after the 3rd clk edge counting the first edge sampling the input high.
REQ-021 A width counter SHALL count cycles spent in UP (positive) or DOWN (negative), saturating at +127/-127.
REQ-022 On UP->BOTH or DOWN->BOTH, phase_err SHALL load the signed count and err_valid SHALL pulse for that cycle; IDLE->BOTH loads 0 and pulses.
REQ-023 Lock counter: each err_valid with |phase_err|<=LOCK_WIN increments (saturating at LOCK_CNT); otherwise clears to 0.
REQ-024 lock SHALL be 1 iff lock counter == LOCK_CNT; it SHALL drop the cycle after an out-of-window err_valid.
REQ-025 enable=0 SHALL force IDLE, up=down=0, err_valid=0, clear width and lock counters and lock; phase_err holds; synchronizers keep running.
REQ-026 Re-enable SHALL resume from IDLE; no edge is inferred from history captured while disabled.

Reset
REQ-027 rst SHALL set state IDLE, up=0, down=0, phase_err=0, err_valid=0, lock=0, all counters 0, sync and history flops 0.
REQ-028 rst asserted mid-pulse SHALL deassert up/down on the next clk edge; rst overrides enable.

Structure
REQ-029 State enum pfd_state_t and PFD_ERR_W=8 SHALL live in the shared package alongside the EEnet types.
REQ-030 The 2-flop synchronizer + edge detector SHALL be one sub-module, dms_edge_sync, instantiated twice.

Verification
REQ-031 ref and fb 100 clk period, ref leads by 10 clk -> up high 10 cycles, then both high 2 cycles, phase_err=+10, err_valid pulse.
REQ-032 fb leads ref by 5 clk -> down high 5 cycles, both 2 cycles, phase_err=-5.
REQ-033 Edges in same clk cycle for 64 periods -> up/down only in BOTH, phase_err=0, lock=1 after 64th err_valid; then one 5-clk offset -> lock=0.
REQ-034 ref at 2x fb frequency -> up held across repeated ref edges, phase_err saturates to +127 when lead exceeds 127.
REQ-035 rst and enable=0 each asserted while up=1 -> up=down=0 next cycle, lock=0, FSM IDLE; resume produces correct next measurement.
